// File: rtl/cache_reg_pkg.sv
// Shared types and widths for the cache/register-file responder.
// Contents: FSM state enum, op-type enum, lane counts, lane-index widths,
// latency counter width, write-lane masks and the op counter width.
package cache_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_t;

    localparam int unsigned CACHE_LANES = 6;
    localparam int unsigned REG_LANES   = 8;
    localparam int unsigned CACHE_IDX_W = 3;
    localparam int unsigned REG_IDX_W   = 3;
    localparam int unsigned LAT_W       = 4;
    localparam int unsigned REG_ADDR_W  = 4;
    localparam int unsigned REG_DEPTH   = 16;
    localparam int unsigned OPS_W       = 16;

    // Lanes below the read lanes are write lanes (lowest index = highest priority).
    localparam logic [CACHE_LANES-1:0] CACHE_WR_MASK = 6'b00_0111;
    localparam logic [REG_LANES-1:0]   REG_WR_MASK   = 8'b0000_1111;

endpackage

// File: rtl/lane_arbiter.sv
// Per-lane arm flags plus fixed-priority pick (lane 0 highest).
// Ports:
//   clk, rst   - clock, async active-high reset (arms set to 1)
//   en         - lane enables
//   take       - the owning FSM accepts the current pick this cycle
//   req_any_c  - at least one lane is enabled and armed
//   grant_c    - one-hot grant of the winning lane
//   idx_c      - binary index of the winning lane
module lane_arbiter #(
    parameter int unsigned LANES = 6,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] en,
    input  logic             take,
    output logic             req_any_c,
    output logic [LANES-1:0] grant_c,
    output logic [IDX_W-1:0] idx_c
);

    logic [LANES-1:0] arm;
    logic [LANES-1:0] pend;

    assign pend      = en & arm;
    assign req_any_c = |pend;

    // Scan from the top so the lowest pending lane is the last (winning) write.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant_c    = '0;
                grant_c[i] = 1'b1;
                idx_c      = IDX_W'(i);
            end
        end
    end

    // Accepted lane disarms; any lane seen low re-arms for its next rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm <= '1;
        end else begin
            arm <= (arm & ~(grant_c & {LANES{take}})) | ~en;
        end
    end

endmodule

// File: rtl/cache_reg_responder.sv
// Responder for the cache/register-file req/ack protocol.
// A 6-lane cache unit (3 write, 3 read) and an 8-lane register unit
// (4 write, 4 read) each run an IDLE -> BUSY -> DONE sequence. Register
// writes store the cache read latch, giving the cache->register path.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   cache_we_*/cache_wa_*/data_*   - cache write lanes
//   cache_re_*/cache_ra_*          - cache read lanes
//   reg_we_*/reg_wa_*              - register write lanes
//   reg_re_*/reg_ra_*              - register read lanes
//   cache_rdata, reg_rdata         - read latches
//   cache_ack, reg_ack             - unit idle/ready levels
//   cache_req, reg_req             - one-cycle completion strobes
//   cache_ops, reg_ops             - completed-op counters (XFER_CNT_EN only)
// Build option: define XFER_CNT_EN to add the op counters.
module cache_reg_responder
    import cache_reg_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned CACHE_LAT = 2,
    parameter int unsigned REG_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cache_we_1,
    input  logic                  cache_we_2,
    input  logic                  cache_we_3,
    input  logic [ADDR_W-1:0]     cache_wa_1,
    input  logic [ADDR_W-1:0]     cache_wa_2,
    input  logic [ADDR_W-1:0]     cache_wa_3,
    input  logic [N-1:0]          data_1,
    input  logic [N-1:0]          data_2,
    input  logic [N-1:0]          data_3,
    input  logic                  cache_re_1,
    input  logic                  cache_re_2,
    input  logic                  cache_re_3,
    input  logic [ADDR_W-1:0]     cache_ra_1,
    input  logic [ADDR_W-1:0]     cache_ra_2,
    input  logic [ADDR_W-1:0]     cache_ra_3,
    input  logic                  reg_we_1,
    input  logic                  reg_we_2,
    input  logic                  reg_we_3,
    input  logic                  reg_we_4,
    input  logic [REG_ADDR_W-1:0] reg_wa_1,
    input  logic [REG_ADDR_W-1:0] reg_wa_2,
    input  logic [REG_ADDR_W-1:0] reg_wa_3,
    input  logic [REG_ADDR_W-1:0] reg_wa_4,
    input  logic                  reg_re_1,
    input  logic                  reg_re_2,
    input  logic                  reg_re_3,
    input  logic                  reg_re_4,
    input  logic [REG_ADDR_W-1:0] reg_ra_1,
    input  logic [REG_ADDR_W-1:0] reg_ra_2,
    input  logic [REG_ADDR_W-1:0] reg_ra_3,
    input  logic [REG_ADDR_W-1:0] reg_ra_4,
    output logic [N-1:0]          cache_rdata,
    output logic [N-1:0]          reg_rdata,
    output logic                  cache_ack,
    output logic                  reg_ack,
    output logic                  cache_req,
    output logic                  reg_req
`ifdef XFER_CNT_EN
    ,
    output logic [OPS_W-1:0]      cache_ops,
    output logic [OPS_W-1:0]      reg_ops
`endif
);

    // ---------------- lane gathering ----------------
    logic [CACHE_LANES-1:0] c_en;
    logic [REG_LANES-1:0]   r_en;
    logic [ADDR_W-1:0]      c_addr [CACHE_LANES];
    logic [N-1:0]           c_wd   [CACHE_LANES];
    logic [REG_ADDR_W-1:0]  r_addr [REG_LANES];

    assign c_en = {cache_re_3, cache_re_2, cache_re_1, cache_we_3, cache_we_2, cache_we_1};
    assign r_en = {reg_re_4, reg_re_3, reg_re_2, reg_re_1, reg_we_4, reg_we_3, reg_we_2, reg_we_1};

    assign c_addr[0] = cache_wa_1;
    assign c_addr[1] = cache_wa_2;
    assign c_addr[2] = cache_wa_3;
    assign c_addr[3] = cache_ra_1;
    assign c_addr[4] = cache_ra_2;
    assign c_addr[5] = cache_ra_3;
    assign c_wd[0]   = data_1;
    assign c_wd[1]   = data_2;
    assign c_wd[2]   = data_3;
    assign c_wd[3]   = '0;
    assign c_wd[4]   = '0;
    assign c_wd[5]   = '0;
    assign r_addr[0] = reg_wa_1;
    assign r_addr[1] = reg_wa_2;
    assign r_addr[2] = reg_wa_3;
    assign r_addr[3] = reg_wa_4;
    assign r_addr[4] = reg_ra_1;
    assign r_addr[5] = reg_ra_2;
    assign r_addr[6] = reg_ra_3;
    assign r_addr[7] = reg_ra_4;

    // ---------------- arbiters ----------------
    logic                   c_any_c, r_any_c, c_take_c, r_take_c;
    logic [CACHE_LANES-1:0] c_grant_c;
    logic [REG_LANES-1:0]   r_grant_c;
    logic [CACHE_IDX_W-1:0] c_idx_c;
    logic [REG_IDX_W-1:0]   r_idx_c;

    lane_arbiter #(.LANES(CACHE_LANES), .IDX_W(CACHE_IDX_W)) u_cache_arb (
        .clk(clk), .rst(rst), .en(c_en), .take(c_take_c),
        .req_any_c(c_any_c), .grant_c(c_grant_c), .idx_c(c_idx_c)
    );

    lane_arbiter #(.LANES(REG_LANES), .IDX_W(REG_IDX_W)) u_reg_arb (
        .clk(clk), .rst(rst), .en(r_en), .take(r_take_c),
        .req_any_c(r_any_c), .grant_c(r_grant_c), .idx_c(r_idx_c)
    );

    // ---------------- FSM state registers ----------------
    state_t           c_state, c_state_nxt, r_state, r_state_nxt;
    logic [LAT_W-1:0] c_cnt, c_cnt_nxt, r_cnt, r_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_state <= ST_IDLE;
            r_state <= ST_IDLE;
            c_cnt   <= '0;
            r_cnt   <= '0;
        end else begin
            c_state <= c_state_nxt;
            r_state <= r_state_nxt;
            c_cnt   <= c_cnt_nxt;
            r_cnt   <= r_cnt_nxt;
        end
    end

    // Cache unit next-state.
    always_comb begin
        c_state_nxt = c_state;
        c_cnt_nxt   = c_cnt;
        c_take_c    = 1'b0;
        unique case (c_state)
            ST_IDLE: if (c_any_c) begin
                c_take_c    = 1'b1;
                c_state_nxt = ST_BUSY;
                c_cnt_nxt   = LAT_W'(CACHE_LAT - 1);
            end
            ST_BUSY: if (c_cnt == '0) c_state_nxt = ST_DONE;
                     else             c_cnt_nxt   = c_cnt - LAT_W'(1);
            ST_DONE: c_state_nxt = ST_IDLE;
            default: c_state_nxt = ST_IDLE;
        endcase
    end

    // Register unit next-state.
    always_comb begin
        r_state_nxt = r_state;
        r_cnt_nxt   = r_cnt;
        r_take_c    = 1'b0;
        unique case (r_state)
            ST_IDLE: if (r_any_c) begin
                r_take_c    = 1'b1;
                r_state_nxt = ST_BUSY;
                r_cnt_nxt   = LAT_W'(REG_LAT - 1);
            end
            ST_BUSY: if (r_cnt == '0) r_state_nxt = ST_DONE;
                     else             r_cnt_nxt   = r_cnt - LAT_W'(1);
            ST_DONE: r_state_nxt = ST_IDLE;
            default: r_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    op_t                   c_op, r_op;
    logic [ADDR_W-1:0]     c_addr_q;
    logic [N-1:0]          c_data_q;
    logic [REG_ADDR_W-1:0] r_addr_q;
    logic [N-1:0]          cache_mem [2**ADDR_W];
    logic [N-1:0]          reg_file  [REG_DEPTH];

    // Status levels, captured request fields and read latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_ack   <= 1'b1;
            reg_ack     <= 1'b1;
            cache_req   <= 1'b0;
            reg_req     <= 1'b0;
            cache_rdata <= '0;
            reg_rdata   <= '0;
            c_op        <= OP_WR;
            r_op        <= OP_WR;
            c_addr_q    <= '0;
            c_data_q    <= '0;
            r_addr_q    <= '0;
        end else begin
            cache_ack <= (c_state_nxt == ST_IDLE);
            reg_ack   <= (r_state_nxt == ST_IDLE);
            cache_req <= (c_state_nxt == ST_DONE);
            reg_req   <= (r_state_nxt == ST_DONE);
            if (c_take_c) begin
                c_op     <= (|(c_grant_c & CACHE_WR_MASK)) ? OP_WR : OP_RD;
                c_addr_q <= c_addr[c_idx_c];
                c_data_q <= c_wd[c_idx_c];
            end
            if (r_take_c) begin
                r_op     <= (|(r_grant_c & REG_WR_MASK)) ? OP_WR : OP_RD;
                r_addr_q <= r_addr[r_idx_c];
            end
            if (c_state == ST_DONE && c_op == OP_RD) cache_rdata <= cache_mem[c_addr_q];
            if (r_state == ST_DONE && r_op == OP_RD) reg_rdata   <= reg_file[r_addr_q];
        end
    end

    // Cache array is not reset; written only on a write DONE.
    always_ff @(posedge clk) begin
        if (c_state == ST_DONE && c_op == OP_WR) cache_mem[c_addr_q] <= c_data_q;
    end

    // Register file takes the cache read latch as it stands in the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_DEPTH); i++) reg_file[i] <= '0;
        end else if (r_state == ST_DONE && r_op == OP_WR) begin
            reg_file[r_addr_q] <= cache_rdata;
        end
    end

`ifdef XFER_CNT_EN
    // Completed-op counters, free-running with natural 16-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_ops <= '0;
            reg_ops   <= '0;
        end else begin
            if (c_state == ST_DONE) cache_ops <= cache_ops + OPS_W'(1);
            if (r_state == ST_DONE) reg_ops   <= reg_ops + OPS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cache_reg_responder.sv
// Self-checking bench for cache_reg_responder: a transaction-level model
// (phase countdown per unit, arm bits, associative cache, register array)
// is compared against the DUT on every falling edge, plus literal checks.
module tb_cache_reg_responder;

    localparam int N = 32;
    localparam int ADDR_W = 12;
    localparam int CACHE_LAT = 2;
    localparam int REG_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    logic              c_we [3];
    logic              c_re [3];
    logic [ADDR_W-1:0] c_wa [3];
    logic [ADDR_W-1:0] c_ra [3];
    logic [N-1:0]      c_d  [3];
    logic              r_we [4];
    logic              r_re [4];
    logic [3:0]        r_wa [4];
    logic [3:0]        r_ra [4];
    logic [N-1:0] cache_rdata, reg_rdata;
    logic cache_ack, reg_ack, cache_req, reg_req;
`ifdef XFER_CNT_EN
    logic [15:0] cache_ops, reg_ops;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int c_pulses = 0;
    int r_pulses = 0;

    always #5 clk = ~clk;

    cache_reg_responder #(.N(N), .ADDR_W(ADDR_W), .CACHE_LAT(CACHE_LAT), .REG_LAT(REG_LAT)) dut (
        .clk(clk), .rst(rst),
        .cache_we_1(c_we[0]), .cache_we_2(c_we[1]), .cache_we_3(c_we[2]),
        .cache_wa_1(c_wa[0]), .cache_wa_2(c_wa[1]), .cache_wa_3(c_wa[2]),
        .data_1(c_d[0]), .data_2(c_d[1]), .data_3(c_d[2]),
        .cache_re_1(c_re[0]), .cache_re_2(c_re[1]), .cache_re_3(c_re[2]),
        .cache_ra_1(c_ra[0]), .cache_ra_2(c_ra[1]), .cache_ra_3(c_ra[2]),
        .reg_we_1(r_we[0]), .reg_we_2(r_we[1]), .reg_we_3(r_we[2]), .reg_we_4(r_we[3]),
        .reg_wa_1(r_wa[0]), .reg_wa_2(r_wa[1]), .reg_wa_3(r_wa[2]), .reg_wa_4(r_wa[3]),
        .reg_re_1(r_re[0]), .reg_re_2(r_re[1]), .reg_re_3(r_re[2]), .reg_re_4(r_re[3]),
        .reg_ra_1(r_ra[0]), .reg_ra_2(r_ra[1]), .reg_ra_3(r_ra[2]), .reg_ra_4(r_ra[3]),
        .cache_rdata(cache_rdata), .reg_rdata(reg_rdata),
        .cache_ack(cache_ack), .reg_ack(reg_ack),
        .cache_req(cache_req), .reg_req(reg_req)
`ifdef XFER_CNT_EN
        , .cache_ops(cache_ops), .reg_ops(reg_ops)
`endif
    );

    // ---------------- reference model ----------------
    // *_ph counts cycles until the unit is idle again: LAT+1 after accept,
    // the op completes on the edge where it reaches 0, strobe while it is 1.
    int c_ph, r_ph, c_ln, r_ln, pick;
    bit c_arm [6];
    bit r_arm [8];
    bit en6 [6];
    bit en8 [8];
    logic [ADDR_W-1:0] c_a;
    logic [N-1:0]      c_dq;
    logic [3:0]        r_a;
    logic [N-1:0]      m_cmem [int];
    logic [N-1:0]      m_reg  [16];
    logic [N-1:0]      m_crd, m_rrd;
    int m_cops, m_rops;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_ph = 0; r_ph = 0; m_crd = '0; m_rrd = '0; m_cops = 0; m_rops = 0;
            for (int i = 0; i < 6; i++) c_arm[i] = 1'b1;
            for (int i = 0; i < 8; i++) r_arm[i] = 1'b1;
            for (int i = 0; i < 16; i++) m_reg[i] = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin en6[i] = c_we[i]; en6[i+3] = c_re[i]; end
            for (int i = 0; i < 4; i++) begin en8[i] = r_we[i]; en8[i+4] = r_re[i]; end
            // Register unit first: a write completing now sees the old cache latch.
            if (r_ph > 0) begin
                r_ph--;
                if (r_ph == 0) begin
                    m_rops++;
                    if (r_ln < 4) m_reg[r_a] = m_crd;
                    else          m_rrd = m_reg[r_a];
                end
            end else begin
                pick = -1;
                for (int i = 7; i >= 0; i--) if (en8[i] && r_arm[i]) pick = i;
                if (pick >= 0) begin
                    r_ln = pick;
                    r_a = (pick < 4) ? r_wa[pick] : r_ra[pick-4];
                    r_ph = REG_LAT + 1;
                    r_arm[pick] = 1'b0;
                end
            end
            if (c_ph > 0) begin
                c_ph--;
                if (c_ph == 0) begin
                    m_cops++;
                    if (c_ln < 3) m_cmem[int'(c_a)] = c_dq;
                    else          m_crd = m_cmem.exists(int'(c_a)) ? m_cmem[int'(c_a)] : '0;
                end
            end else begin
                pick = -1;
                for (int i = 5; i >= 0; i--) if (en6[i] && c_arm[i]) pick = i;
                if (pick >= 0) begin
                    c_ln = pick;
                    c_a = (pick < 3) ? c_wa[pick] : c_ra[pick-3];
                    c_dq = (pick < 3) ? c_d[pick] : '0;
                    c_ph = CACHE_LAT + 1;
                    c_arm[pick] = 1'b0;
                end
            end
            for (int i = 0; i < 6; i++) if (!en6[i]) c_arm[i] = 1'b1;
            for (int i = 0; i < 8; i++) if (!en8[i]) r_arm[i] = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("cache_ack", N'(cache_ack), N'(c_ph == 0));
            chk("reg_ack", N'(reg_ack), N'(r_ph == 0));
            chk("cache_req", N'(cache_req), N'(c_ph == 1));
            chk("reg_req", N'(reg_req), N'(r_ph == 1));
            chk("cache_rdata", cache_rdata, m_crd);
            chk("reg_rdata", reg_rdata, m_rrd);
`ifdef XFER_CNT_EN
            chk("cache_ops", N'(cache_ops), N'(m_cops % 65536));
            chk("reg_ops", N'(reg_ops), N'(m_rops % 65536));
`endif
            if (cache_req) c_pulses++;
            if (reg_req) r_pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) begin c_we[i] = 0; c_re[i] = 0; end
        for (int i = 0; i < 4; i++) begin r_we[i] = 0; r_re[i] = 0; end
    endtask

    // Waits for the unit's strobe, then returns 2 time units after the completing edge.
    task automatic wait_req(input bit reg_unit);
        int k;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if ((reg_unit ? reg_req : cache_req) === 1'b1) break;
            k++;
        end
        if (k >= 50) chk(reg_unit ? "reg_req_timeout" : "cache_req_timeout", N'(0), N'(1));
        @(posedge clk);
        #2;
    endtask

    task automatic cache_op(input int lane, input logic [ADDR_W-1:0] a, input logic [N-1:0] d);
        if (lane < 3) begin c_we[lane] = 1; c_wa[lane] = a; c_d[lane] = d; end
        else begin c_re[lane-3] = 1; c_ra[lane-3] = a; end
        wait_req(0);
        clear_all();
        tick(1);
    endtask

    task automatic reg_op(input int lane, input logic [3:0] a);
        if (lane < 4) begin r_we[lane] = 1; r_wa[lane] = a; end
        else begin r_re[lane-4] = 1; r_ra[lane-4] = a; end
        wait_req(1);
        clear_all();
        tick(1);
    endtask

    logic [N-1:0] pre [8];
    int base;

    initial begin
        rst = 1'b0;
        clear_all();
        for (int i = 0; i < 3; i++) begin c_wa[i] = '0; c_ra[i] = '0; c_d[i] = '0; end
        for (int i = 0; i < 4; i++) begin r_wa[i] = '0; r_ra[i] = '0; end
        #1 rst = 1'b1;
        tick(3);
        chk("rst_cache_ack", N'(cache_ack), N'(1));
        chk("rst_reg_ack", N'(reg_ack), N'(1));
        chk("rst_cache_req", N'(cache_req), N'(0));
        chk("rst_cache_rdata", cache_rdata, 32'h0);
        chk("rst_reg_rdata", reg_rdata, 32'h0);
        rst = 1'b0;
        tick(2);

        // First write: ack low through BUSY x2 and DONE, strobe in DONE.
        c_we[0] = 1; c_wa[0] = 12'h000; c_d[0] = 32'h2;
        @(posedge clk);
        @(negedge clk); chk("wr_ack_busy1", N'(cache_ack), N'(0));
        @(negedge clk); chk("wr_ack_busy2", N'(cache_ack), N'(0));
        chk("wr_req_busy2", N'(cache_req), N'(0));
        @(negedge clk); chk("wr_req_done", N'(cache_req), N'(1));
        chk("wr_ack_done", N'(cache_ack), N'(0));
        @(negedge clk); chk("wr_ack_back", N'(cache_ack), N'(1));
        chk("wr_req_gone", N'(cache_req), N'(0));
        @(posedge clk); #2;
        clear_all();
        tick(1);
        cache_op(3, 12'h000, '0);
        chk("rd0_value", cache_rdata, 32'h2);

        // Simultaneous write lane 2 and read lane 1 on the same address.
        c_we[1] = 1; c_wa[1] = 12'h001; c_d[1] = 32'h2;
        c_re[0] = 1; c_ra[0] = 12'h001;
        wait_req(0);
        c_we[1] = 0;
        wait_req(0);
        clear_all();
        tick(1);
        chk("wr_then_rd1", cache_rdata, 32'h2);

        // Cache -> register transfer, then a held write enable.
        cache_op(3, 12'h000, '0);
        reg_op(0, 4'd0);
        reg_op(4, 4'd0);
        chk("xfer_reg_rdata", reg_rdata, 32'h2);
        base = r_pulses;
        r_we[0] = 1; r_wa[0] = 4'd0;
        wait_req(1);
        tick(20);
        chk("held_we_once", N'(r_pulses - base), N'(1));
        clear_all();
        tick(1);

        // Alternating register write/read on address 2.
        base = r_pulses;
        for (int it = 0; it < 29; it++) begin
            reg_op(2, 4'd2);
            reg_op(6, 4'd2);
            chk("toggle_rd", reg_rdata, m_crd);
        end
        chk("toggle_pulses", N'(r_pulses - base), N'(58));

        // Preload cache addresses 0..7 with known values.
        for (int i = 0; i < 8; i++) begin
            pre[i] = $urandom;
            cache_op(i % 3, ADDR_W'(i), pre[i]);
        end

        // Reset during BUSY of a write to 0x002 aborts it.
        c_we[0] = 1; c_wa[0] = 12'h002; c_d[0] = ~pre[2];
        tick(2);
        chk("abort_busy_ack", N'(cache_ack), N'(0));
        rst = 1'b1;
        #1;
        chk("abort_ack_now", N'(cache_ack), N'(1));
        chk("abort_no_req", N'(cache_req), N'(0));
        clear_all();
        tick(2);
        rst = 1'b0;
        tick(2);
        cache_op(3, 12'h002, '0);
        chk("abort_prior", cache_rdata, pre[2]);
        reg_op(4, 4'd2);
        chk("rst_regfile_clear", reg_rdata, 32'h0);

        // Randomized traffic on all 14 lanes.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(4, 0) == 0) c_we[i] = ~c_we[i];
                if ($urandom_range(4, 0) == 0) c_re[i] = ~c_re[i];
                c_wa[i] = ADDR_W'($urandom_range(7, 0));
                c_ra[i] = ADDR_W'($urandom_range(7, 0));
                c_d[i] = $urandom;
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(4, 0) == 0) r_we[i] = ~r_we[i];
                if ($urandom_range(4, 0) == 0) r_re[i] = ~r_re[i];
                r_wa[i] = 4'($urandom_range(15, 0));
                r_ra[i] = 4'($urandom_range(15, 0));
            end
            tick(1);
        end
        clear_all();
        tick(10);
        chk("final_cache_idle", N'(cache_ack), N'(1));
        chk("final_reg_idle", N'(reg_ack), N'(1));
`ifdef XFER_CNT_EN
        chk("cache_ops_vs_strobes", N'(cache_ops), N'(c_pulses % 65536));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
